// File: rtl/div23_seq_u64.sv
// Sequential unsigned 64-bit divide-by-23: BPC radix-2 remainder stages per cycle, MSB first.
// Optional macro DIV23_EARLY_OUT_EN: small operands (x < 23) bypass RUN and go straight to DONE.
module div23_seq_u64 #(
    parameter int unsigned BPC     = 4,
    parameter int unsigned DIVISOR = 23
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_x,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_q,
    output logic [4:0]  out_r,
    output logic        busy
);
    localparam int unsigned Steps = 64 / BPC;
    localparam int unsigned CntW  = 6;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    if (DIVISOR != 23) begin : g_bad_divisor
        $error("div23_seq_u64: only DIVISOR=23 is supported");
    end
    if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8 || BPC == 16)) begin : g_bad_bpc
        $error("div23_seq_u64: BPC must be one of 1,2,4,8,16");
    end

    state_e            state_q;
    logic [63:0]       x_q;
    logic [63:0]       q_q;
    logic [4:0]        r_q;
    logic [CntW-1:0]   cnt_q;
    logic [4:0]        r_step;
    logic [BPC-1:0]    q_bits;
    logic              early;

    // Returns {quotient bit, next remainder}; unreachable remainders 23..31 collapse to zero.
    function automatic logic [5:0] stage(input logic [4:0] r, input logic b);
        logic [5:0] t;
        t = {r, b};
        if (r > 5'd22) begin
            return 6'd0;
        end else if (t >= 6'd23) begin
            return {1'b1, 5'(t - 6'd23)};
        end else begin
            return {1'b0, t[4:0]};
        end
    endfunction

    always_comb begin
        logic [5:0] s;
        s      = '0;
        r_step = r_q;
        q_bits = '0;
        for (int i = 0; i < int'(BPC); i++) begin
            s                 = stage(r_step, x_q[63-i]);
            q_bits[BPC-1-i]   = s[5];
            r_step            = s[4:0];
        end
    end

`ifdef DIV23_EARLY_OUT_EN
    assign early = (in_x[63:5] == '0) && (in_x[4:0] < 5'd23);
`else
    assign early = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            x_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        q_q <= '0;
                        if (early) begin
                            x_q     <= '0;
                            r_q     <= in_x[4:0];
                            cnt_q   <= '0;
                            state_q <= StDone;
                        end else begin
                            x_q     <= in_x;
                            r_q     <= '0;
                            cnt_q   <= CntW'(Steps - 1);
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    x_q <= x_q << BPC;
                    q_q <= {q_q[63-BPC:0], q_bits};
                    r_q <= r_step;
                    if (cnt_q == '0) begin
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // All outputs decode registers only, so no input-to-handshake combinational path exists.
    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StRun) || (state_q == StDone);
    assign out_q     = q_q;
    assign out_r     = r_q;

endmodule

// File: tb/tb_div23_seq_u64.sv
// Directed and short random checks for div23_seq_u64: results, latency, back-pressure, reset.
module tb_div23_seq_u64;
    localparam int unsigned BPC   = 4;
    localparam int unsigned Steps = 64 / BPC;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_x;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_q;
    logic [4:0]  out_r;
    logic        busy;

    int checks = 0;
    int errors = 0;

    div23_seq_u64 #(.BPC(BPC), .DIVISOR(23)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_r     (out_r),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] x;
        logic [63:0] q;
        logic [4:0]  r;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_latency(input logic [63:0] x);
`ifdef DIV23_EARLY_OUT_EN
        if (x < 64'd23) return 0;
`endif
        return Steps;
    endfunction

    // Issue one dividend, measure edges from accept to out_valid, then consume after hold cycles.
    task automatic run_op(input logic [63:0] x, input int hold,
                          output logic [63:0] q, output logic [4:0] r, output int lat);
        int waitc;
        q   = '0;
        r   = '0;
        lat = -1;
        @(negedge clk);
        in_x     = x;
        in_valid = 1'b1;
        waitc    = 0;
        while (!in_ready && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("busy_after_accept", 64'(busy), 64'd1);
        chk("in_ready_after_accept", 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) begin
            chk("out_valid_timeout", 64'(out_valid), 64'd1);
            return;
        end
        q = out_q;
        r = out_r;
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        chk("hold_q_stable", out_q, q);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("in_ready_after_done", 64'(in_ready), 64'd1);
        chk("out_valid_after_done", 64'(out_valid), 64'd0);
    endtask

    vec_t        vecs[12];
    logic [63:0] q;
    logic [4:0]  r;
    int          lat;

    initial begin
        vecs[0]  = '{x: 64'd100, q: 64'd4, r: 5'd8};
        vecs[1]  = '{x: 64'd23, q: 64'd1, r: 5'd0};
        vecs[2]  = '{x: 64'd22, q: 64'd0, r: 5'd22};
        vecs[3]  = '{x: 64'hFFFF_FFFF_FFFF_FFFF, q: 64'd802032351030850070, r: 5'd5};
        vecs[4]  = '{x: 64'd0, q: 64'd0, r: 5'd0};
        vecs[5]  = '{x: 64'd46, q: 64'd2, r: 5'd0};
        vecs[6]  = '{x: 64'd1000, q: 64'd43, r: 5'd11};
        vecs[7]  = '{x: 64'd12345, q: 64'd536, r: 5'd17};
        vecs[8]  = '{x: 64'h1_0000_0000, q: 64'd186737708, r: 5'd12};
        vecs[9]  = '{x: 64'd5, q: 64'd0, r: 5'd5};
        vecs[10] = '{x: 64'd24, q: 64'd1, r: 5'd1};
        vecs[11] = '{x: 64'd32, q: 64'd1, r: 5'd9};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_x      = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_q", out_q, 64'd0);
        chk("rst_out_r", 64'(out_r), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].x, i % 3, q, r, lat);
            chk("vec_q", q, vecs[i].q);
            chk("vec_r", 64'(r), 64'(vecs[i].r));
            chk("vec_latency", 64'(lat), 64'(exp_latency(vecs[i].x)));
        end

        // Back-pressure: result held for 10 cycles while a competing dividend is offered.
        @(negedge clk);
        in_x     = 64'd1000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_x = 64'd5;
        lat  = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("bp_reached_done", 64'(out_valid), 64'd1);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_out_q", out_q, 64'd43);
            chk("bp_out_r", 64'(out_r), 64'd11);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_release_valid", 64'(out_valid), 64'd0);
        chk("bp_release_ready", 64'(in_ready), 64'd1);

        // Asynchronous reset during the third RUN cycle.
        @(negedge clk);
        in_x     = 64'd12345;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_out_q", out_q, 64'd0);
        chk("mid_rst_out_r", 64'(out_r), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(64'd46, 0, q, r, lat);
        chk("post_rst_q", q, 64'd2);
        chk("post_rst_r", 64'(r), 64'd0);

        // Short random sweep against the native 64-bit divide.
        for (int i = 0; i < 200; i++) begin
            logic [63:0] x;
            x = {$urandom(), $urandom()};
            if (i % 4 == 1) x = x >> $urandom_range(0, 63);
            run_op(x, int'($urandom_range(0, 3)), q, r, lat);
            chk("rand_q", q, x / 64'd23);
            chk("rand_r", 64'(r), x % 64'd23);
            chk("rand_recon", q * 64'd23 + 64'(r), x);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
